// File: rtl/frame_render_sequencer.sv
// Frame-synchronous renderer for the 160x120 framebuffer.
// Each frame_start latches a snapshot of the game state and then raster-scans
// every pixel. For each pixel it looks up the dino sprite ROM, picks the
// highest-priority layer and writes one plot per cycle to the VGA adapter.
module frame_render_sequencer #(
  parameter int         XMAX        = 159,
  parameter int         YMAX        = 119,
  parameter int         ROM_LATENCY = 1,
  parameter int         DINO_LEFT   = 15,
  parameter int         DINO_W      = 10,
  parameter int         DINO_H      = 12,
  parameter int         OBS_W       = 12,
  parameter int         GROUND_TOP  = 105,
  parameter logic [2:0] COL_BG      = 3'b011,
  parameter logic [2:0] COL_GRND    = 3'b110,
  parameter logic [2:0] COL_OBS1    = 3'b100,
  parameter logic [2:0] COL_OBS2    = 3'b101,
  parameter logic [2:0] COL_TRANSP  = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic [7:0] dino_y,
  input  logic [7:0] obs1_x,
  input  logic [7:0] obs2_x,
  input  logic [7:0] obs1_h,
  input  logic [7:0] obs2_h,
  input  logic [8:0] sprite_base,
  output logic [8:0] sprite_addr,
  input  logic [2:0] sprite_color,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, LATCH, SWEEP, DRAIN, DONE} state_t;

  localparam logic [7:0] XMAX_C       = 8'(XMAX);
  localparam logic [6:0] YMAX_C       = 7'(YMAX);
  // The drain covers the ROM read latency plus the output register, so the
  // last plot is followed directly by the frame_done cycle.
  localparam logic [2:0] DRAIN_LAST   = 3'(ROM_LATENCY);
  localparam logic [8:0] DINO_LEFT_C  = 9'(DINO_LEFT);
  localparam logic [8:0] DINO_RIGHT_C = 9'(DINO_LEFT + DINO_W);
  localparam logic [8:0] DINO_W_C     = 9'(DINO_W);
  localparam logic [8:0] DINO_H_C     = 9'(DINO_H);
  localparam logic [8:0] OBS_W_C      = 9'(OBS_W);
  localparam logic [8:0] GROUND_C     = 9'(GROUND_TOP);
  localparam logic [7:0] GROUND_C8    = 8'(GROUND_TOP);

  state_t     state;
  state_t     state_next;

  logic [7:0] xc;
  logic [6:0] yc;
  logic [2:0] drain_cnt;
  logic       last_coord;

  logic [7:0] dino_y_s;
  logic [7:0] obs1_x_s;
  logic [7:0] obs2_x_s;
  logic [7:0] obs1_h_s;
  logic [7:0] obs2_h_s;
  logic [8:0] base_s;

  logic [8:0] x9;
  logic [8:0] y9;
  logic [8:0] obs1_top;
  logic [8:0] obs2_top;
  logic       in_gnd;
  logic       in_dino;
  logic       in_obs1;
  logic       in_obs2;
  logic       issue;

  // Flag order in each stage: {ground, dino, obs1, obs2}
  logic       vld_p  [1:ROM_LATENCY];
  logic [7:0] x_p    [1:ROM_LATENCY];
  logic [6:0] y_p    [1:ROM_LATENCY];
  logic [3:0] flag_p [1:ROM_LATENCY];
  logic [2:0] pix_color;

  assign last_coord = (xc == XMAX_C) && (yc == YMAX_C);
  assign issue      = (state == SWEEP);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic plus the busy / frame_done status decoded from the state
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_next = LATCH;
      end
      LATCH: begin
        busy       = 1'b1;
        state_next = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (last_coord) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = frame_start ? LATCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot the game state in LATCH and run the raster / drain counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xc        <= '0;
      yc        <= '0;
      drain_cnt <= '0;
      dino_y_s  <= '0;
      obs1_x_s  <= '0;
      obs2_x_s  <= '0;
      obs1_h_s  <= '0;
      obs2_h_s  <= '0;
      base_s    <= '0;
    end else begin
      case (state)
        LATCH: begin
          dino_y_s <= dino_y;
          obs1_x_s <= obs1_x;
          obs2_x_s <= obs2_x;
          obs1_h_s <= obs1_h;
          obs2_h_s <= obs2_h;
          base_s   <= sprite_base;
          xc       <= '0;
          yc       <= '0;
        end
        SWEEP: begin
          drain_cnt <= '0;
          if (xc == XMAX_C) begin
            xc <= '0;
            yc <= yc + 7'd1;
          end else begin
            xc <= xc + 8'd1;
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Sticky overrun: a new request while a frame is still in flight
  always_ff @(posedge clk) begin
    if (!resetn)                 overrun <= 1'b0;
    else if (frame_start && busy) overrun <= 1'b1;
  end

  // Stage 0: region tests in 9-bit arithmetic so edge obstacles never wrap,
  // and the sprite address for the current coordinate
  always_comb begin
    x9       = {1'b0, xc};
    y9       = {2'b0, yc};
    obs1_top = (obs1_h_s >= GROUND_C8) ? 9'd0 : GROUND_C - {1'b0, obs1_h_s};
    obs2_top = (obs2_h_s >= GROUND_C8) ? 9'd0 : GROUND_C - {1'b0, obs2_h_s};
    in_gnd   = (y9 >= GROUND_C);
    in_dino  = (x9 >= DINO_LEFT_C) && (x9 < DINO_RIGHT_C) &&
               (y9 >= {1'b0, dino_y_s}) && (y9 < ({1'b0, dino_y_s} + DINO_H_C));
    in_obs1  = (obs1_h_s != 8'd0) &&
               (x9 >= {1'b0, obs1_x_s}) && (x9 < ({1'b0, obs1_x_s} + OBS_W_C)) &&
               (y9 >= obs1_top) && (y9 < GROUND_C);
    in_obs2  = (obs2_h_s != 8'd0) &&
               (x9 >= {1'b0, obs2_x_s}) && (x9 < ({1'b0, obs2_x_s} + OBS_W_C)) &&
               (y9 >= obs2_top) && (y9 < GROUND_C);
    sprite_addr = 9'd0;
    if (issue)
      sprite_addr = base_s + (x9 - DINO_LEFT_C) + (y9 - {1'b0, dino_y_s}) * DINO_W_C;
  end

  // Delay coordinates and region flags alongside the sprite ROM read
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        x_p[i]    <= '0;
        y_p[i]    <= '0;
        flag_p[i] <= '0;
      end
    end else begin
      vld_p[1]  <= issue;
      x_p[1]    <= xc;
      y_p[1]    <= yc;
      flag_p[1] <= {in_gnd, in_dino, in_obs1, in_obs2};
      for (int i = 2; i <= ROM_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        x_p[i]    <= x_p[i-1];
        y_p[i]    <= y_p[i-1];
        flag_p[i] <= flag_p[i-1];
      end
    end
  end

  // Layer priority: ground, opaque dino pixel, obstacle 1, obstacle 2, background
  always_comb begin
    pix_color = COL_BG;
    if (flag_p[ROM_LATENCY][3])                                         pix_color = COL_GRND;
    else if (flag_p[ROM_LATENCY][2] && (sprite_color != COL_TRANSP))    pix_color = sprite_color;
    else if (flag_p[ROM_LATENCY][1])                                    pix_color = COL_OBS1;
    else if (flag_p[ROM_LATENCY][0])                                    pix_color = COL_OBS2;
  end

  // Registered plot port; x/y/color hold their value while no plot is issued
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x     <= '0;
      y     <= '0;
      color <= COL_BG;
      plot  <= 1'b0;
    end else if (vld_p[ROM_LATENCY]) begin
      x     <= x_p[ROM_LATENCY];
      y     <= y_p[ROM_LATENCY];
      color <= pix_color;
      plot  <= 1'b1;
    end else begin
      plot  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_render_sequencer.sv
// Scoreboard bench for frame_render_sequencer.
// Stimulus pushes every expected plot of a frame into a queue; a monitor on
// the falling edge pops and compares each plot, and keeps a framebuffer copy
// for spot checks of hand-computed pixels.
module tb_frame_render_sequencer;

  localparam logic [2:0] COL_BG     = 3'b011;
  localparam logic [2:0] COL_GRND   = 3'b110;
  localparam logic [2:0] COL_OBS1   = 3'b100;
  localparam logic [2:0] COL_OBS2   = 3'b101;
  localparam logic [2:0] COL_TRANSP = 3'b010;
  localparam int         FRAME_LEN  = 19203;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_start;
  logic [7:0] dino_y, obs1_x, obs2_x, obs1_h, obs2_h;
  logic [8:0] sprite_base;
  logic [8:0] sprite_addr;
  logic [2:0] sprite_color = 3'b000;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, busy, frame_done, overrun;

  int         cyc = 0;
  int         c0 = 0;
  int         done_len = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;
  logic [2:0] fb [0:159][0:119];
  int         run_len = 0;
  int         last_plot_cyc = 0;
  logic [14:0] first_xy = '0;
  logic [14:0] last_xy = '0;
  logic       prev_plot = 1'b0;

  frame_render_sequencer dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start),
    .dino_y(dino_y), .obs1_x(obs1_x), .obs2_x(obs2_x),
    .obs1_h(obs1_h), .obs2_h(obs2_h), .sprite_base(sprite_base),
    .sprite_addr(sprite_addr), .sprite_color(sprite_color),
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Sprite ROM, one cycle of latency: transparent at address 0, black elsewhere
  always @(posedge clk) sprite_color <= (sprite_addr == 9'd0) ? COL_TRANSP : 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] modelColor(input int px, input int py, input int dy,
                                            input int o1x, input int o1h,
                                            input int o2x, input int o2h, input int base);
    int addr, top1, top2;
    if (py >= 105) return COL_GRND;
    if (px >= 15 && px < 25 && py >= dy && py < dy + 12) begin
      addr = (base + (px - 15) + (py - dy) * 10) % 512;
      if (addr != 0) return 3'b000;
    end
    top1 = (105 - o1h < 0) ? 0 : 105 - o1h;
    top2 = (105 - o2h < 0) ? 0 : 105 - o2h;
    if (o1h != 0 && px >= o1x && px < o1x + 12 && py >= top1) return COL_OBS1;
    if (o2h != 0 && px >= o2x && px < o2x + 12 && py >= top2) return COL_OBS2;
    return COL_BG;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every plot is matched against the head of the scoreboard queue
  always @(negedge clk) begin
    if (plot) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_plot", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput($sformatf("pixel(%0d,%0d)", mon_exp[17:10], mon_exp[9:3]),
                    int'({x, y, color}), int'(mon_exp));
      end
      if (x <= 8'd159 && y <= 7'd119) fb[x][y] = color;
      if (!prev_plot) begin
        run_len  = 0;
        first_xy = {x, y};
      end
      run_len++;
      last_xy       = {x, y};
      last_plot_cyc = cyc;
    end
    prev_plot = plot;
  end

  task automatic pushFrame(input int dy, input int o1x, input int o1h,
                           input int o2x, input int o2h, input int base);
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        exp_q.push_back({8'(xx), 7'(yy), modelColor(xx, yy, dy, o1x, o1h, o2x, o2h, base)});
  endtask

  task automatic applyStimulus(input int dy, input int o1x, input int o1h,
                               input int o2x, input int o2h, input int base);
    @(negedge clk);
    dino_y      = 8'(dy);
    obs1_x      = 8'(o1x);
    obs1_h      = 8'(o1h);
    obs2_x      = 8'(o2x);
    obs2_h      = 8'(o2h);
    sprite_base = 9'(base);
    frame_start = 1'b1;
    pushFrame(dy, o1x, o1h, o2x, o2h, base);
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Returns at the falling edge inside the frame_done cycle
  task automatic waitFrameDone(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 25000; i++) begin
      if (frame_done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_done_seen"}, int'(found), 1);
    done_len = cyc - c0;
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_frame_len"}, done_len, FRAME_LEN);
    checkOutput({tag, "_run_len"}, run_len, 19200);
    checkOutput({tag, "_first_xy"}, int'(first_xy), 0);
    checkOutput({tag, "_last_xy"}, int'(last_xy), int'({8'd159, 7'd119}));
    checkOutput({tag, "_done_after_last"}, cyc - last_plot_cyc, 1);
    checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    resetn      = 1'b0;
    frame_start = 1'b0;
    dino_y      = 8'd0;
    obs1_x      = 8'd0;
    obs2_x      = 8'd0;
    obs1_h      = 8'd0;
    obs2_h      = 8'd0;
    sprite_base = 9'd0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_plot", int'(plot), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_x", int'(x), 0);
    checkOutput("rst_y", int'(y), 0);
    checkOutput("rst_color", int'(color), int'(COL_BG));
    checkOutput("rst_sprite_addr", int'(sprite_addr), 0);
    resetn = 1'b1;

    // Frame 1: full-frame timing plus transparent dino pixel over obstacle 1
    applyStimulus(93, 15, 7, 200, 0, 462);
    waitFrameDone("f1");
    checkFrame("f1");
    checkOutput("f1_px_15_98", int'(fb[15][98]), int'(COL_OBS1));
    checkOutput("f1_px_16_98", int'(fb[16][98]), 0);
    checkOutput("f1_px_15_105", int'(fb[15][105]), int'(COL_GRND));
    checkOutput("f1_px_27_97", int'(fb[27][97]), int'(COL_BG));
    checkOutput("f1_overrun", int'(overrun), 0);
    @(negedge clk);
    checkOutput("f1_done_pulse", int'(frame_done), 0);
    checkOutput("f1_busy_after", int'(busy), 0);

    // Frame A: right-edge obstacle, off-screen tall obstacle, mid-frame
    // dino_y change and an overrun request
    applyStimulus(93, 150, 20, 254, 200, 0);
    repeat (2000) @(negedge clk);
    dino_y = 8'd73;
    repeat (1000) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("fa_overrun_set", int'(overrun), 1);
    checkOutput("fa_busy_mid", int'(busy), 1);
    waitFrameDone("fa");
    checkFrame("fa");
    checkOutput("fa_px_149_100", int'(fb[149][100]), int'(COL_BG));
    checkOutput("fa_px_150_100", int'(fb[150][100]), int'(COL_OBS1));
    checkOutput("fa_px_159_100", int'(fb[159][100]), int'(COL_OBS1));
    checkOutput("fa_px_0_100", int'(fb[0][100]), int'(COL_BG));
    checkOutput("fa_px_5_50", int'(fb[5][50]), int'(COL_BG));
    checkOutput("fa_px_0_110", int'(fb[0][110]), int'(COL_GRND));
    checkOutput("fa_px_16_93", int'(fb[16][93]), 0);
    checkOutput("fa_px_16_104", int'(fb[16][104]), 0);
    checkOutput("fa_px_16_92", int'(fb[16][92]), int'(COL_BG));
    checkOutput("fa_px_16_73", int'(fb[16][73]), int'(COL_BG));

    // Frame B: request on the DONE cycle goes straight to LATCH
    frame_start = 1'b1;
    pushFrame(73, 150, 20, 254, 200, 0);
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("fb_b2b_busy", int'(busy), 1);
    checkOutput("fb_b2b_done_low", int'(frame_done), 0);
    waitFrameDone("fb");
    checkFrame("fb");
    checkOutput("fb_px_16_73", int'(fb[16][73]), 0);
    checkOutput("fb_px_16_84", int'(fb[16][84]), 0);
    checkOutput("fb_px_16_85", int'(fb[16][85]), int'(COL_BG));
    checkOutput("fb_px_16_93", int'(fb[16][93]), int'(COL_BG));
    checkOutput("fb_overrun_held", int'(overrun), 1);

    // Reset in the middle of a frame at plotted coordinate (80,60)
    applyStimulus(50, 40, 30, 100, 50, 0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 25000; i++) begin
        @(negedge clk);
        if (plot && x == 8'd80 && y == 7'd60) begin
          hit = 1'b1;
          break;
        end
      end
      checkOutput("mid_reset_point_seen", int'(hit), 1);
    end
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("mr_plot", int'(plot), 0);
    checkOutput("mr_busy", int'(busy), 0);
    checkOutput("mr_x", int'(x), 0);
    checkOutput("mr_y", int'(y), 0);
    checkOutput("mr_color", int'(color), int'(COL_BG));
    checkOutput("mr_overrun", int'(overrun), 0);
    checkOutput("mr_sprite_addr", int'(sprite_addr), 0);
    exp_q.delete();
    resetn = 1'b1;

    // Restart after the abort begins again at (0,0)
    applyStimulus(50, 40, 30, 100, 50, 0);
    repeat (400) @(negedge clk);
    checkOutput("rs_first_xy", int'(first_xy), 0);
    checkOutput("rs_progress", exp_q.size(), 19200 - run_len);
    checkOutput("rs_busy", int'(busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
